cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the core. Owns the program counter, the instruction register and the instruction-fetch handshake. Steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK, driving `instr_decoder` (`instr`, `ce`) and gating its register-file write enable so architectural state changes only in WRITEBACK. Halts on a debug request or on an unsupported opcode.

---
 rtl/cpu_sequencer_pkg.sv | 47 ++++
 rtl/cpu_sequencer_fetch_port.sv | 37 +++
 rtl/cpu_sequencer.sv | 113 +++++++++++
 tb/tb_cpu_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: instruction formats, sequencer state encoding and opcode support helper
package cpu_sequencer_pkg;

   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_OP_IMM = 7'b0010011,
      OP_OP     = 7'b0110011
   } opcode_t;

   typedef struct packed {
      logic [24:0] payload;
      opcode_t     opcode;
   } instr_any_t;

   typedef struct packed {
      logic [19:0] imm;
      logic [4:0]  rd;
      opcode_t     opcode;
   } instr_u_t;

   typedef union packed {
      logic [31:0] raw;
      instr_any_t  any;
      instr_u_t    u;
   } instr_t;

   typedef struct packed {
      logic regfile_we;
   } decoder_ctl_signals_t;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } seq_state_t;

   function automatic logic is_supported_opcode(input logic [6:0] op);
      return op == OP_LUI || op == OP_AUIPC;
   endfunction

endpackage

// File: rtl/cpu_sequencer_fetch_port.sv
// imem_fetch_port: fetch request hold-until-ack and instruction-register capture
// Ports:
//   clk, rst          core clock, async active-high reset (drops any outstanding request)
//   start             raise the request at the next edge
//   pc                address to present while requesting
//   imem_ack/rdata    memory acknowledge and instruction word (same cycle)
//   imem_req/addr     request and address to memory (address 0 when idle)
//   instr             instruction register, loaded only on an accepted fetch
//   fetched           request accepted this cycle
module imem_fetch_port
   import cpu_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] pc,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output instr_t      instr,
   output logic        fetched
);

   assign fetched   = imem_req & imem_ack;
   assign imem_addr = imem_req ? pc : '0;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         imem_req <= 1'b0;
         instr    <= '0;
      end else begin
         imem_req <= start | (imem_req & ~imem_ack);
         if (fetched) instr <= imem_rdata;
      end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK/HALT control with PC and retire counter
// Ports:
//   clk, rst            core clock, async active-high reset
//   imem_*              instruction fetch handshake (request held until ack)
//   instr               instruction register to the decoder
//   decode_ce, exec_ce  one-cycle enables in DECODE and EXECUTE
//   dec_ctl             decoder control bundle; its write enable is gated to WRITEBACK
//   regfile_we          gated register-file write enable
//   pc, instret         current instruction address, retired-instruction count
//   halt_req, resume    stop at next instruction boundary / leave HALT
//   halted, illegal     in HALT / unsupported opcode seen in DECODE
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 imem_req,
   output logic [31:0]          imem_addr,
   input  logic                 imem_ack,
   input  logic [31:0]          imem_rdata,
   output instr_t               instr,
   output logic                 decode_ce,
   output logic                 exec_ce,
   input  decoder_ctl_signals_t dec_ctl,
   output logic                 regfile_we,
   output logic [31:0]          pc,
   output logic [31:0]          instret,
   input  logic                 halt_req,
   input  logic                 resume,
   output logic                 halted,
   output logic                 illegal
);

   seq_state_t state;
   logic       fetched;
   logic       start;
   logic       wb;

   // The request is (re)armed for every cycle that enters FETCH; the first term
   // covers the idle FETCH cycle right after reset, where no request is yet up.
   assign start = (state == S_FETCH && !imem_req) ||
                  (state == S_WRITEBACK && !halt_req) ||
                  (state == S_HALT && resume);

   assign regfile_we = wb & dec_ctl.regfile_we;

   imem_fetch_port u_fetch (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pc         (pc),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .instr      (instr),
      .fetched    (fetched)
   );

   // Per-state enables are registered on entry to their state, so each is a
   // clean one-cycle pulse aligned with that state.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= S_FETCH;
         pc        <= RESET_PC;
         instret   <= '0;
         decode_ce <= 1'b0;
         exec_ce   <= 1'b0;
         wb        <= 1'b0;
         illegal   <= 1'b0;
         halted    <= 1'b0;
      end else begin
         decode_ce <= 1'b0;
         exec_ce   <= 1'b0;
         wb        <= 1'b0;
         illegal   <= 1'b0;
         case (state)
            S_FETCH:
               if (fetched) begin
                  state     <= S_DECODE;
                  decode_ce <= 1'b1;
                  illegal   <= !is_supported_opcode(imem_rdata[6:0]);
               end
            S_DECODE:
               if (is_supported_opcode(instr.any.opcode)) begin
                  state   <= S_EXECUTE;
                  exec_ce <= 1'b1;
               end else begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end
            S_EXECUTE: begin
               state <= S_WRITEBACK;
               wb    <= 1'b1;
            end
            S_WRITEBACK: begin
               pc      <= pc + PC_STEP;
               instret <= instret + 32'd1;
               state   <= halt_req ? S_HALT : S_FETCH;
               halted  <= halt_req;
            end
            S_HALT:
               if (resume) begin
                  state  <= S_FETCH;
                  halted <= 1'b0;
               end
            default: state <= S_FETCH;
         endcase
      end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and randomized instruction stream against a transaction-level model
module tb_cpu_sequencer;
   import cpu_sequencer_pkg::*;

   localparam logic [31:0] RPC   = 32'h0000_0100;
   localparam logic [31:0] RPC_W = 32'hFFFF_FFFC;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 imem_ack = 1'b0;
   logic [31:0]          imem_rdata = '0;
   logic                 halt_req = 1'b0;
   logic                 resume = 1'b0;
   decoder_ctl_signals_t dec_ctl = '0;

   logic        imem_req, decode_ce, exec_ce, regfile_we, halted, illegal;
   logic [31:0] imem_addr, pc, instret;
   instr_t      instr;
   logic        imem_req_w, decode_ce_w, exec_ce_w, regfile_we_w, halted_w, illegal_w;
   logic [31:0] imem_addr_w, pc_w, instret_w;
   instr_t      instr_w;

   cpu_sequencer #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
      .decode_ce(decode_ce), .exec_ce(exec_ce), .dec_ctl(dec_ctl),
      .regfile_we(regfile_we), .pc(pc), .instret(instret), .halt_req(halt_req),
      .resume(resume), .halted(halted), .illegal(illegal)
   );

   cpu_sequencer #(.RESET_PC(RPC_W)) dut_w (
      .clk(clk), .rst(rst), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr_w),
      .decode_ce(decode_ce_w), .exec_ce(exec_ce_w), .dec_ctl(dec_ctl),
      .regfile_we(regfile_we_w), .pc(pc_w), .instret(instret_w), .halt_req(halt_req),
      .resume(resume), .halted(halted_w), .illegal(illegal_w)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] m_pc, m_instret, m_instr;
   logic        ill;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic legal(input logic [31:0] w);
      return w[6:0] == 7'b0110111 || w[6:0] == 7'b0010111;
   endfunction

   function automatic logic [31:0] rand_word(input int kind);
      logic [31:0] r;
      r = $urandom();
      if (kind == 0) return {r[31:7], 7'b0110111};
      if (kind == 1) return {r[31:7], 7'b0010111};
      while (legal(r)) r = $urandom();
      return r;
   endfunction

   // The wrap instance sees identical stimulus, so its PC is the model PC shifted by the reset offset.
   task automatic chk_pc();
      chk("pc", pc, m_pc);
      chk("pc_w", pc_w, m_pc + (RPC_W - RPC));
      chk("instret", instret, m_instret);
      chk("instret_w", instret_w, m_instret);
   endtask

   task automatic run_instr(input logic [31:0] w, input int wt, input logic we,
                            input logic hreq, output logic is_ill);
      halt_req = hreq;
      for (int i = 0; i < wt; i++) begin
         chk("req_wait", imem_req, 1);
         chk("addr_wait", imem_addr, m_pc);
         chk("instr_hold", instr, m_instr);
         imem_rdata = $urandom();
         step();
      end
      chk("req", imem_req, 1);
      chk("addr", imem_addr, m_pc);
      chk("instr_hold_ack", instr, m_instr);
      chk_pc();
      imem_ack = 1'b1;
      imem_rdata = w;
      step();
      imem_ack = 1'b0;
      imem_rdata = $urandom();
      m_instr = w;
      is_ill = !legal(w);
      chk("decode_ce", decode_ce, 1);
      chk("req_drop", imem_req, 0);
      chk("instr", instr, w);
      chk("illegal", illegal, is_ill);
      chk("halted_dec", halted, 0);
      if (is_ill) begin
         step();
         halt_req = 1'b0;
         chk("halted_ill", halted, 1);
         chk("illegal_once", illegal, 0);
         chk("req_ill", imem_req, 0);
         chk_pc();
         return;
      end
      dec_ctl.regfile_we = we;
      step();
      chk("exec_ce", exec_ce, 1);
      chk("decode_ce_off", decode_ce, 0);
      chk("we_exec", regfile_we, 0);
      step();
      chk("regfile_we", regfile_we, we);
      chk("exec_ce_off", exec_ce, 0);
      chk_pc();
      step();
      halt_req = 1'b0;
      dec_ctl.regfile_we = 1'($urandom_range(0, 1));
      m_pc = m_pc + 32'd4;
      m_instret = m_instret + 32'd1;
      chk("we_off", regfile_we, 0);
      chk_pc();
      chk("halted_wb", halted, hreq);
      chk("req_next", imem_req, !hreq);
   endtask

   task automatic do_resume(input logic hr);
      for (int i = 0; i < 2; i++) begin
         resume = 1'b0;
         halt_req = 1'($urandom_range(0, 1));
         chk("halt_hold", halted, 1);
         chk("req_halt", imem_req, 0);
         step();
      end
      resume = 1'b1;
      halt_req = hr;
      step();
      resume = 1'b0;
      halt_req = 1'b0;
      chk("resumed", halted, 0);
      chk("req_resume", imem_req, 1);
      chk("addr_resume", imem_addr, m_pc);
   endtask

   initial begin
      m_pc = RPC;
      m_instret = '0;
      m_instr = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_instr", instr, 0);
      chk("rst_dce", decode_ce, 0);
      chk("rst_ece", exec_ce, 0);
      chk("rst_we", regfile_we, 0);
      chk("rst_halted", halted, 0);
      chk("rst_illegal", illegal, 0);
      chk_pc();
      rst = 1'b0;
      chk("idle_req", imem_req, 0);
      step();
      // LUI x1,0x12345 with zero-wait memory; the wrap instance rolls over to 0
      run_instr(32'h1234_50B7, 0, 1'b1, 1'b0, ill);
      chk("pc_wrap", pc_w, 32'h0);
      run_instr(rand_word(1), 3, 1'b1, 1'b0, ill);
      run_instr(32'h0000_0000, 1, 1'b1, 1'b0, ill);
      do_resume(1'b0);
      run_instr(32'h0000_0000, 0, 1'b0, 1'b0, ill);
      do_resume(1'b0);
      run_instr(rand_word(0), 2, 1'b0, 1'b1, ill);
      do_resume(1'b1);
      run_instr(rand_word(1), 0, 1'b1, 1'b0, ill);
      for (int n = 0; n < 30; n++) begin
         int k;
         logic hr;
         k = $urandom_range(0, 9);
         hr = ($urandom_range(0, 4) == 0);
         run_instr(rand_word(k == 0 ? 2 : k & 1), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), hr, ill);
         if (ill || hr) do_resume(1'($urandom_range(0, 1)));
      end
      // reset in the middle of a fetch wait drops the request asynchronously
      halt_req = 1'b0;
      step();
      chk("req_before_rst", imem_req, 1);
      rst = 1'b1;
      #1;
      chk("req_async_drop", imem_req, 0);
      m_pc = RPC;
      m_instret = '0;
      m_instr = '0;
      chk_pc();
      chk("instr_rst", instr, 0);
      step();
      rst = 1'b0;
      chk("req_after_rst", imem_req, 0);
      step();
      run_instr(rand_word(0), 1, 1'b1, 1'b0, ill);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
